// File: rtl/up3_core_p_if.sv
// up3_core_p_if: memory bus between the UP3 core and its single-port synchronous RAM.
//
// Parameters:
//   DW - data/instruction word width
//   AW - address width
//
// Signals:
//   mem_addr  - RAM address, driven by the core
//   mem_wdata - RAM write data, driven by the core (always the accumulator)
//   mem_we    - RAM write enable, driven by the core
//   mem_q     - RAM read data, driven by the RAM one cycle after the address
//
// Modports:
//   master - the core side
//   slave  - the RAM side
interface up3_core_p_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_q
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_q
  );
endinterface

// File: rtl/up3_core_p.sv
// up3_core_p: parametrised UP3 accumulator CPU (datapath plus control FSM).
//
// Two-word instructions are fetched from an external synchronous RAM with a
// one-cycle read latency. Supports immediate/memory ALU ops, stores, jumps,
// N/Z conditional branches, CALL/RET through an internal return stack, HLT,
// and a run/idle gate.
//
// Parameters:
//   DW          - data/instruction word width (DW >= AW, DW >= 4)
//   AW          - memory address and PC width
//   STACK_DEPTH - return-stack entries (>= 1)
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   run     - fetch enable, sampled in IDLE and at instruction end
//   mem     - RAM bus (master modport)
//   state   - FSM state: IDLE=0 F1=1 F2=2 F3=3 EX1=4 EX2=5 HALT=6
//   pc      - program counter
//   opcode  - instruction register upper (IRU)
//   value   - instruction register lower (IRL), the operand
//   ac      - accumulator
//   zflg    - zero flag of ac
//   nflg    - negative flag of ac
//   halted  - high while in HALT
//   stk_err - sticky return-stack overflow/underflow error
module up3_core_p #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  up3_core_p_if.master        mem,
  output logic [2:0]          state,
  output logic [AW-1:0]       pc,
  output logic [3:0]          opcode,
  output logic [DW-1:0]       value,
  output logic [DW-1:0]       ac,
  output logic                zflg,
  output logic                nflg,
  output logic                halted,
  output logic                stk_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JN   = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_F3   = 3'd3,
    S_EX1  = 3'd4,
    S_EX2  = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t cur_state, next_state;

  logic [AW-1:0]   pc_next;
  logic [DW-1:0]   ac_new;
  logic            ac_wr;
  logic            ld_op;
  logic            ld_val;
  logic            push;
  logic            pop;
  logic            set_err;
  logic [SP_W-1:0] sp;
  logic            stk_full;
  logic            stk_empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic [AW-1:0]   stack [STACK_DEPTH];
  logic [AW-1:0]   operand_addr;

  assign state        = cur_state;
  assign halted       = (cur_state == S_HALT);
  assign operand_addr = value[AW-1:0];

  // Memory bus: the operand address is presented only during EX1, which is
  // what lets the RAM return the operand in EX2 and accept STA writes.
  assign mem.mem_addr  = (cur_state == S_EX1) ? operand_addr : pc;
  assign mem.mem_we    = (cur_state == S_EX1) && (opcode == OP_STA);
  assign mem.mem_wdata = ac;

  // Stack pointer counts occupied entries; the top entry sits at sp-1.
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign push_idx  = IDX_W'(sp);
  assign top_idx   = IDX_W'(sp - SP_W'(1));

  // Next-state and datapath control decode.
  always_comb begin
    next_state = cur_state;
    pc_next    = pc;
    ac_new     = ac;
    ac_wr      = 1'b0;
    ld_op      = 1'b0;
    ld_val     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    set_err    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (run) next_state = S_F1;
      end
      S_F1: begin
        pc_next    = pc + AW'(1);
        next_state = S_F2;
      end
      S_F2: begin
        ld_op      = 1'b1;
        pc_next    = pc + AW'(1);
        next_state = S_F3;
      end
      S_F3: begin
        ld_val     = 1'b1;
        next_state = S_EX1;
      end
      S_EX1: begin
        next_state = run ? S_F1 : S_IDLE;
        case (opcode)
          OP_NOP: ;
          OP_LDI: begin
            ac_new = value;
            ac_wr  = 1'b1;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_XOR: next_state = S_EX2;
          OP_STA: ;
          OP_JMP: pc_next = operand_addr;
          OP_JZ:  if (zflg) pc_next = operand_addr;
          OP_JN:  if (nflg) pc_next = operand_addr;
          OP_CALL: begin
            // pc already points past the operand, so it is the return address.
            if (stk_full) begin
              set_err    = 1'b1;
              next_state = S_HALT;
            end else begin
              push    = 1'b1;
              pc_next = operand_addr;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              set_err    = 1'b1;
              next_state = S_HALT;
            end else begin
              pop     = 1'b1;
              pc_next = stack[top_idx];
            end
          end
          OP_NOT: begin
            ac_new = ~ac;
            ac_wr  = 1'b1;
          end
          OP_SHL: begin
            ac_new = {ac[DW-2:0], 1'b0};
            ac_wr  = 1'b1;
          end
          OP_HLT: next_state = S_HALT;
          default: ;
        endcase
      end
      S_EX2: begin
        ac_wr      = 1'b1;
        next_state = run ? S_F1 : S_IDLE;
        case (opcode)
          OP_LDA:  ac_new = mem.mem_q;
          OP_ADD:  ac_new = ac + mem.mem_q;
          OP_SUB:  ac_new = ac - mem.mem_q;
          OP_AND:  ac_new = ac & mem.mem_q;
          OP_XOR:  ac_new = ac ^ mem.mem_q;
          default: ac_new = ac;
        endcase
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // State and architectural registers; flags always follow the new ac value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
      pc        <= '0;
      opcode    <= '0;
      value     <= '0;
      ac        <= '0;
      zflg      <= 1'b1;
      nflg      <= 1'b0;
      stk_err   <= 1'b0;
      sp        <= '0;
    end else begin
      cur_state <= next_state;
      pc        <= pc_next;
      if (ld_op)  opcode <= mem.mem_q[3:0];
      if (ld_val) value  <= mem.mem_q;
      if (ac_wr) begin
        ac   <= ac_new;
        zflg <= (ac_new == '0);
        nflg <= ac_new[DW-1];
      end
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
      if (set_err) stk_err <= 1'b1;
    end
  end

  // Return-stack storage; contents are meaningless above sp so no reset.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc;
  end

endmodule

// File: tb/tb_up3_core_p.sv
// tb_up3_core_p: directed self-checking bench for up3_core_p.
//
// Runs small hand-assembled programs (DW=8, AW=8, STACK_DEPTH=2) against a
// behavioural one-cycle-latency RAM and compares registers against
// hand-computed values at known cycle counts or after HALT.
module tb_up3_core_p;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [3:0]    opcode;
  logic [DW-1:0] value;
  logic [DW-1:0] ac;
  logic          zflg;
  logic          nflg;
  logic          halted;
  logic          stk_err;

  int checks   = 0;
  int failures = 0;

  up3_core_p_if #(.DW(DW), .AW(AW)) bus ();

  up3_core_p #(.DW(DW), .AW(AW), .STACK_DEPTH(SD)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .mem     (bus.master),
    .state   (state),
    .pc      (pc),
    .opcode  (opcode),
    .value   (value),
    .ac      (ac),
    .zflg    (zflg),
    .nflg    (nflg),
    .halted  (halted),
    .stk_err (stk_err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a bench-side load port and a bulk clear.
  logic [7:0] ram [256];
  logic       load_we   = 1'b0;
  logic       clear_ram = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;

  always @(posedge clk) begin
    if (clear_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (load_we) begin
      ram[load_addr] <= load_data;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_q <= ram[bus.mem_addr];
  end

  // Count write-enable cycles and any that occur outside EX1.
  int we_count = 0;
  int we_bad   = 0;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      we_count++;
      if (state != 3'd4) we_bad++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the core in reset and wipe the RAM.
  task automatic applyReset();
    reset = 1'b0;
    run   = 1'b0;
    #1;
    clear_ram = 1'b1;
    tick(1);
    clear_ram = 1'b0;
  endtask

  // Load one word into RAM (core held in reset).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick(1);
    load_we = 1'b0;
  endtask

  task automatic loadInstr(input logic [7:0] a, input logic [7:0] op, input logic [7:0] arg);
    applyStimulus(a, op);
    applyStimulus(a + 8'd1, arg);
  endtask

  task automatic startRun();
    reset = 1'b1;
    run   = 1'b1;
  endtask

  task automatic runUntilHalt(input string tag, input int bound);
    for (int i = 0; i < bound && !halted; i++) tick(1);
    checkOutput(tag, halted, 1'b1);
  endtask

  int we_start;
  int bad_start;

  initial begin
    reset = 1'b0;
    run   = 1'b0;

    // Reset state.
    applyReset();
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_op", opcode, 4'h0);
    checkOutput("rst_value", value, 8'h00);
    checkOutput("rst_ac", ac, 8'h00);
    checkOutput("rst_z", zflg, 1'b1);
    checkOutput("rst_n", nflg, 1'b0);
    checkOutput("rst_err", stk_err, 1'b0);
    checkOutput("rst_halt", halted, 1'b0);
    checkOutput("rst_we", bus.mem_we, 1'b0);

    // LDI 05; ADD [20]=FD wraps to 02.
    loadInstr(8'h00, 8'h01, 8'h05);
    loadInstr(8'h02, 8'h04, 8'h20);
    applyStimulus(8'h20, 8'hFD);
    startRun();
    tick(5);
    checkOutput("t1_ldi_ac", ac, 8'h05);
    checkOutput("t1_ldi_state", state, 3'd1);
    tick(4);
    checkOutput("t1_ex2_state", state, 3'd5);
    checkOutput("t1_ex2_ac", ac, 8'h05);
    tick(1);
    checkOutput("t1_add_ac", ac, 8'h02);
    checkOutput("t1_add_z", zflg, 1'b0);
    checkOutput("t1_add_n", nflg, 1'b0);
    checkOutput("t1_add_pc", pc, 8'h04);

    // ALU chain: LDI 0F, AND 3C, XOR FF, SUB F4, NOT, LDA 81, SHL, HLT.
    applyReset();
    loadInstr(8'h00, 8'h01, 8'h0F);
    loadInstr(8'h02, 8'h06, 8'h40);
    loadInstr(8'h04, 8'h07, 8'h41);
    loadInstr(8'h06, 8'h05, 8'h42);
    loadInstr(8'h08, 8'h0D, 8'h00);
    loadInstr(8'h0A, 8'h02, 8'h43);
    loadInstr(8'h0C, 8'h0E, 8'h00);
    loadInstr(8'h0E, 8'h0F, 8'h00);
    applyStimulus(8'h40, 8'h3C);
    applyStimulus(8'h41, 8'hFF);
    applyStimulus(8'h42, 8'hF4);
    applyStimulus(8'h43, 8'h81);
    startRun();
    tick(15);
    checkOutput("t2_xor_ac", ac, 8'hF3);
    tick(5);
    checkOutput("t2_sub_ac", ac, 8'hFF);
    checkOutput("t2_sub_n", nflg, 1'b1);
    tick(4);
    checkOutput("t2_not_ac", ac, 8'h00);
    checkOutput("t2_not_z", zflg, 1'b1);
    tick(5);
    checkOutput("t2_lda_ac", ac, 8'h81);
    checkOutput("t2_lda_n", nflg, 1'b1);
    tick(4);
    checkOutput("t2_shl_ac", ac, 8'h02);
    checkOutput("t2_shl_n", nflg, 1'b0);
    tick(4);
    checkOutput("t2_halt_state", state, 3'd6);
    checkOutput("t2_halt_pc", pc, 8'h10);
    checkOutput("t2_halted", halted, 1'b1);

    // LDI 00; JZ 10; at 10: STA 30; HLT.
    applyReset();
    loadInstr(8'h00, 8'h01, 8'h00);
    loadInstr(8'h02, 8'h09, 8'h10);
    loadInstr(8'h10, 8'h03, 8'h30);
    loadInstr(8'h12, 8'h0F, 8'h00);
    applyStimulus(8'h30, 8'hAA);
    we_start  = we_count;
    bad_start = we_bad;
    startRun();
    runUntilHalt("t3_halt_wait", 100);
    checkOutput("t3_pc", pc, 8'h14);
    checkOutput("t3_mem30", ram[8'h30], 8'h00);
    checkOutput("t3_we_cycles", we_count - we_start, 1);
    checkOutput("t3_we_outside_ex1", we_bad - bad_start, 0);

    // Branches not taken, then JN and JMP taken.
    applyReset();
    loadInstr(8'h00, 8'h01, 8'h01);
    loadInstr(8'h02, 8'h09, 8'h10);
    loadInstr(8'h04, 8'h0A, 8'h10);
    loadInstr(8'h06, 8'h01, 8'h80);
    loadInstr(8'h08, 8'h0A, 8'h20);
    loadInstr(8'h10, 8'h0F, 8'h00);
    loadInstr(8'h20, 8'h08, 8'h30);
    loadInstr(8'h30, 8'h0F, 8'h00);
    startRun();
    runUntilHalt("t3b_halt_wait", 100);
    checkOutput("t3b_pc", pc, 8'h32);
    checkOutput("t3b_ac", ac, 8'h80);

    // Nested CALL 40 -> CALL 50 -> LDI 07, RET, RET -> HLT at 02.
    applyReset();
    loadInstr(8'h00, 8'h0B, 8'h40);
    loadInstr(8'h02, 8'h0F, 8'h00);
    loadInstr(8'h40, 8'h0B, 8'h50);
    loadInstr(8'h42, 8'h0C, 8'h00);
    loadInstr(8'h50, 8'h01, 8'h07);
    loadInstr(8'h52, 8'h0C, 8'h00);
    startRun();
    runUntilHalt("t4_halt_wait", 100);
    checkOutput("t4_pc", pc, 8'h04);
    checkOutput("t4_ac", ac, 8'h07);
    checkOutput("t4_err", stk_err, 1'b0);

    // Third nested CALL overflows a two-entry stack.
    applyReset();
    loadInstr(8'h00, 8'h0B, 8'h40);
    loadInstr(8'h40, 8'h0B, 8'h50);
    loadInstr(8'h50, 8'h0B, 8'h60);
    loadInstr(8'h60, 8'h01, 8'h33);
    startRun();
    runUntilHalt("t4b_halt_wait", 100);
    checkOutput("t4b_pc", pc, 8'h52);
    checkOutput("t4b_err", stk_err, 1'b1);
    checkOutput("t4b_state", state, 3'd6);
    checkOutput("t4b_ac", ac, 8'h00);

    // RET from empty stack; HALT ignores run.
    applyReset();
    loadInstr(8'h00, 8'h0C, 8'h00);
    startRun();
    runUntilHalt("t5_halt_wait", 50);
    checkOutput("t5_pc", pc, 8'h02);
    checkOutput("t5_err", stk_err, 1'b1);
    checkOutput("t5_state", state, 3'd6);
    run = 1'b0;
    tick(3);
    run = 1'b1;
    tick(3);
    checkOutput("t5_hold_state", state, 3'd6);
    checkOutput("t5_hold_err", stk_err, 1'b1);

    // Drop run in EX1 of ADD: finishes through EX2 then idles.
    applyReset();
    loadInstr(8'h00, 8'h01, 8'h03);
    loadInstr(8'h02, 8'h04, 8'h40);
    applyStimulus(8'h40, 8'h04);
    startRun();
    tick(8);
    checkOutput("t6_ex1_state", state, 3'd4);
    run = 1'b0;
    tick(1);
    checkOutput("t6_ex2_state", state, 3'd5);
    tick(1);
    checkOutput("t6_idle_state", state, 3'd0);
    checkOutput("t6_ac", ac, 8'h07);
    checkOutput("t6_pc", pc, 8'h04);
    tick(3);
    checkOutput("t6_idle_hold", state, 3'd0);
    checkOutput("t6_pc_hold", pc, 8'h04);
    run = 1'b1;
    tick(1);
    checkOutput("t6_resume", state, 3'd1);

    // Reset asserted during EX1 of STA.
    applyReset();
    loadInstr(8'h00, 8'h01, 8'h5A);
    loadInstr(8'h02, 8'h03, 8'h30);
    applyStimulus(8'h30, 8'h11);
    startRun();
    tick(8);
    checkOutput("t7_ex1_state", state, 3'd4);
    checkOutput("t7_ex1_we", bus.mem_we, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("t7_rst_we", bus.mem_we, 1'b0);
    checkOutput("t7_rst_state", state, 3'd0);
    checkOutput("t7_rst_pc", pc, 8'h00);
    checkOutput("t7_rst_ac", ac, 8'h00);
    checkOutput("t7_rst_value", value, 8'h00);
    checkOutput("t7_rst_z", zflg, 1'b1);
    tick(1);
    checkOutput("t7_mem30", ram[8'h30], 8'h11);
    run   = 1'b0;
    reset = 1'b1;
    tick(2);
    checkOutput("t7_idle", state, 3'd0);
    run = 1'b1;
    tick(1);
    checkOutput("t7_f1", state, 3'd1);
    checkOutput("t7_f1_addr", bus.mem_addr, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
